// File: rtl/esp8266_ipd_parser.sv
// Receive-side parser for ESP8266 "+IPD,<id>,<len>:<payload>" frames fed by uart_rx.
// Optional "OK\r\n" detector is built when ESP_OK_DETECT_EN is defined.
module esp8266_ipd_parser #(
    parameter int unsigned MAX_LEN = 2048,
    parameter logic [23:0] TIMEOUT = 24'd5_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_int,
    input  logic [7:0]  rx_data,
    output logic [3:0]  link_id,
    output logic [11:0] pay_len,
    output logic [7:0]  pay_data,
    output logic        pay_valid,
    output logic        frame_start,
    output logic        frame_done,
    output logic        frame_err,
    output logic        ok_seen
);

    localparam logic [2:0] S_HUNT = 3'd0;
    localparam logic [2:0] S_TAG  = 3'd1;
    localparam logic [2:0] S_ID   = 3'd2;
    localparam logic [2:0] S_LEN  = 3'd3;
    localparam logic [2:0] S_PAY  = 3'd4;

    localparam logic [13:0] MAX_LEN_V = 14'(MAX_LEN);

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= 8'h30) && (b <= 8'h39);
    endfunction

    function automatic logic [7:0] tag_char(input logic [1:0] idx);
        case (idx)
            2'd0:    return 8'h49;
            2'd1:    return 8'h50;
            2'd2:    return 8'h44;
            2'd3:    return 8'h2C;
            default: return 8'h00;
        endcase
    endfunction

    logic        rx_int_d;
    logic        bs;
    logic [2:0]  state;
    logic [1:0]  tag_idx;
    logic        id_seen;
    logic [3:0]  id_r;
    logic [13:0] acc;
    logic [2:0]  dig_cnt;
    logic [13:0] remain;
    logic [23:0] tmo_cnt;
    logic [7:0]  digit_val;

    assign bs        = rx_int_d & ~rx_int;
    assign digit_val = rx_data - 8'h30;

    // Delay rx_int so its falling edge can be detected as the byte strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rx_int_d <= 1'b0;
        else        rx_int_d <= rx_int;
    end

    // Frame parser, payload delivery and inter-byte timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_HUNT;
            tag_idx     <= 2'd0;
            id_seen     <= 1'b0;
            id_r        <= 4'd0;
            acc         <= 14'd0;
            dig_cnt     <= 3'd0;
            remain      <= 14'd0;
            tmo_cnt     <= 24'd0;
            link_id     <= 4'd0;
            pay_len     <= 12'd0;
            pay_data    <= 8'd0;
            pay_valid   <= 1'b0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            pay_valid   <= 1'b0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            frame_err   <= 1'b0;
            if (bs) begin
                tmo_cnt <= 24'd0;
                case (state)
                    S_HUNT: begin
                        if (rx_data == 8'h2B) begin
                            state   <= S_TAG;
                            tag_idx <= 2'd0;
                        end
                    end
                    S_TAG: begin
                        if (rx_data == tag_char(tag_idx)) begin
                            if (tag_idx == 2'd3) begin
                                state   <= S_ID;
                                id_seen <= 1'b0;
                            end else begin
                                tag_idx <= tag_idx + 2'd1;
                            end
                        end else if (rx_data == 8'h2B) begin
                            tag_idx <= 2'd0;  // a new '+' may start the real header
                        end else begin
                            state <= S_HUNT;
                        end
                    end
                    S_ID: begin
                        if (!id_seen && is_digit(rx_data)) begin
                            id_r    <= rx_data[3:0];
                            id_seen <= 1'b1;
                        end else if (id_seen && rx_data == 8'h2C) begin
                            acc     <= 14'd0;
                            dig_cnt <= 3'd0;
                            state   <= S_LEN;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= S_HUNT;
                        end
                    end
                    S_LEN: begin
                        if (is_digit(rx_data)) begin
                            if (dig_cnt == 3'd4) begin
                                frame_err <= 1'b1;
                                state     <= S_HUNT;
                            end else begin
                                acc     <= acc * 14'd10 + {6'd0, digit_val};
                                dig_cnt <= dig_cnt + 3'd1;
                            end
                        end else if (rx_data == 8'h3A) begin
                            if (dig_cnt == 3'd0 || acc == 14'd0 || acc > MAX_LEN_V) begin
                                frame_err <= 1'b1;
                                state     <= S_HUNT;
                            end else begin
                                link_id     <= id_r;
                                pay_len     <= acc[11:0];
                                remain      <= acc;
                                frame_start <= 1'b1;
                                state       <= S_PAY;
                            end
                        end else begin
                            frame_err <= 1'b1;
                            state     <= S_HUNT;
                        end
                    end
                    S_PAY: begin
                        pay_data  <= rx_data;
                        pay_valid <= 1'b1;
                        remain    <= remain - 14'd1;
                        if (remain == 14'd1) begin
                            frame_done <= 1'b1;
                            state      <= S_HUNT;
                        end
                    end
                    default: state <= S_HUNT;
                endcase
            end else if (state == S_HUNT) begin
                tmo_cnt <= 24'd0;
            end else if (tmo_cnt == TIMEOUT - 24'd1) begin
                frame_err <= 1'b1;
                state     <= S_HUNT;
                tmo_cnt   <= 24'd0;
            end else begin
                tmo_cnt <= tmo_cnt + 24'd1;
            end
        end
    end

`ifdef ESP_OK_DETECT_EN
    logic [1:0] ok_idx;

    function automatic logic [7:0] ok_char(input logic [1:0] idx);
        case (idx)
            2'd0:    return 8'h4F;
            2'd1:    return 8'h4B;
            2'd2:    return 8'h0D;
            2'd3:    return 8'h0A;
            default: return 8'h00;
        endcase
    endfunction

    // "OK\r\n" matcher; payload bytes never feed it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ok_idx  <= 2'd0;
            ok_seen <= 1'b0;
        end else begin
            ok_seen <= 1'b0;
            if (state == S_PAY) begin
                ok_idx <= 2'd0;
            end else if (bs) begin
                if (rx_data == ok_char(ok_idx)) begin
                    ok_idx <= ok_idx + 2'd1;
                    if (ok_idx == 2'd3) ok_seen <= 1'b1;
                end else if (rx_data == 8'h4F) begin
                    ok_idx <= 2'd1;
                end else begin
                    ok_idx <= 2'd0;
                end
            end
        end
    end
`else
    assign ok_seen = 1'b0;
`endif

endmodule

// File: tb/tb_esp8266_ipd_parser.sv
// Scoreboard bench for esp8266_ipd_parser: expected events are queued as bytes are sent.
module tb_esp8266_ipd_parser;

    localparam logic [23:0] TMO = 24'd100;

    localparam logic [2:0] K_START = 3'd0;
    localparam logic [2:0] K_DATA  = 3'd1;
    localparam logic [2:0] K_ERR   = 3'd2;
    localparam logic [2:0] K_OK    = 3'd3;

    typedef struct packed {
        logic [2:0]  kind;
        logic [3:0]  id;
        logic [11:0] len;
        logic [7:0]  data;
        logic        last;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_int = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic [3:0]  link_id;
    logic [11:0] pay_len;
    logic [7:0]  pay_data;
    logic        pay_valid, frame_start, frame_done, frame_err, ok_seen;

    ev_t exp_q[$];
    int  checks = 0;
    int  failures = 0;
    int  cyc = 0;
    int  last_pv_cyc = 0;
    int  err_cyc = 0;

    esp8266_ipd_parser #(.MAX_LEN(2048), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .rx_int(rx_int), .rx_data(rx_data),
        .link_id(link_id), .pay_len(pay_len), .pay_data(pay_data),
        .pay_valid(pay_valid), .frame_start(frame_start), .frame_done(frame_done),
        .frame_err(frame_err), .ok_seen(ok_seen)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Output monitor: every strobe is matched against the head of the queue.
    always @(negedge clk) begin
        ev_t e;
        if (rst_n) begin
            if (frame_start) begin
                e = '1;
                if (exp_q.size() > 0) e = exp_q.pop_front();
                checks++;
                if (e.kind !== K_START || e.id !== link_id || e.len !== pay_len) begin
                    failures++;
                    $display("FAIL frame_start: got id=%0d len=%0d, expected kind=%0d id=%0d len=%0d",
                             link_id, pay_len, e.kind, e.id, e.len);
                end
            end
            if (pay_valid) begin
                e = '1;
                if (exp_q.size() > 0) e = exp_q.pop_front();
                checks++;
                last_pv_cyc = cyc;
                if (e.kind !== K_DATA || e.data !== pay_data || e.last !== frame_done) begin
                    failures++;
                    $display("FAIL pay_valid: got data=%02h done=%0b, expected kind=%0d data=%02h done=%0b",
                             pay_data, frame_done, e.kind, e.data, e.last);
                end
            end
            if (frame_done && !pay_valid) begin
                checks++;
                failures++;
                $display("FAIL frame_done: got done without pay_valid, expected coincident strobes");
            end
            if (frame_err) begin
                e = '1;
                if (exp_q.size() > 0) e = exp_q.pop_front();
                checks++;
                err_cyc = cyc;
                if (e.kind !== K_ERR) begin
                    failures++;
                    $display("FAIL frame_err: got unexpected err, expected kind=%0d", e.kind);
                end
            end
            if (ok_seen) begin
                e = '1;
                if (exp_q.size() > 0) e = exp_q.pop_front();
                checks++;
                if (e.kind !== K_OK) begin
                    failures++;
                    $display("FAIL ok_seen: got unexpected ok_seen, expected kind=%0d", e.kind);
                end
            end
        end
    end

    task automatic exp_start(input logic [3:0] id, input logic [11:0] len);
        exp_q.push_back('{kind: K_START, id: id, len: len, data: 8'h00, last: 1'b0});
    endtask

    task automatic exp_data(input logic [7:0] d, input logic last);
        exp_q.push_back('{kind: K_DATA, id: 4'd0, len: 12'd0, data: d, last: last});
    endtask

    task automatic exp_err();
        exp_q.push_back('{kind: K_ERR, id: 4'd0, len: 12'd0, data: 8'h00, last: 1'b0});
    endtask

    task automatic exp_ok();
        exp_q.push_back('{kind: K_OK, id: 4'd0, len: 12'd0, data: 8'h00, last: 1'b0});
    endtask

    task automatic exp_payload(input string s);
        for (int i = 0; i < s.len(); i++) exp_data(s[i], (i == s.len() - 1));
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_data = b;
        rx_int  = 1'b1;
        repeat (3) @(posedge clk);
        #1 rx_int = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < int'(TMO) + 50) begin
            @(posedge clk);
            n++;
        end
        repeat (4) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s drain: got %0d events outstanding, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({link_id, pay_len, pay_data, pay_valid, frame_start, frame_done, frame_err, ok_seen} !== 31'd0) begin
            failures++;
            $display("FAIL reset_outputs: got id=%0d len=%0d data=%02h, expected all zero",
                     link_id, pay_len, pay_data);
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
    endtask

    task automatic test_basic();
        exp_start(4'd0, 12'd3);
        exp_payload("abc");
        send_str("+IPD,0,3:abc");
        wait_drain("basic");
    endtask

    task automatic test_echo_and_embedded();
        exp_start(4'd3, 12'd12);
        exp_payload("+IPD,0,1:xxy");
        send_str("AT+CIPMUX=1\r\n+IPD,3,12:+IPD,0,1:xx");
        send_str("y");
        wait_drain("embedded");
    endtask

    task automatic test_bad_headers();
        exp_err(); send_str("+IPD,0,0:");
        exp_err(); send_str("+IPD,0,2049:");
        exp_err(); send_str("+IPD,0,12345:");
        exp_err(); send_str("+IPD,A,1:");
        exp_start(4'd1, 12'd1);
        exp_payload("z");
        send_str("+IPD,1,1:z");
        wait_drain("bad_headers");
    endtask

    task automatic test_timeout();
        exp_start(4'd2, 12'd5);
        exp_data(8'h61, 1'b0);
        exp_data(8'h62, 1'b0);
        exp_err();
        send_str("+IPD,2,5:ab");
        wait_drain("timeout");
        checks++;
        if (err_cyc - last_pv_cyc != int'(TMO)) begin
            failures++;
            $display("FAIL timeout_latency: got %0d cycles, expected %0d", err_cyc - last_pv_cyc, TMO);
        end
        exp_start(4'd2, 12'd1);
        exp_payload("q");
        send_str("+IPD,2,1:q");
        wait_drain("after_timeout");
    endtask

    task automatic test_reset_mid_frame();
        exp_start(4'd5, 12'd9);
        exp_data(8'h61, 1'b0);
        exp_data(8'h62, 1'b0);
        send_str("+IPD,5,9:ab");
        wait_drain("pre_reset");
        @(posedge clk); #1 rst_n = 1'b0;
        #2;
        checks++;
        if ({link_id, pay_len, pay_data, pay_valid, frame_start, frame_done, frame_err, ok_seen} !== 31'd0) begin
            failures++;
            $display("FAIL mid_reset_outputs: got id=%0d len=%0d data=%02h, expected all zero",
                     link_id, pay_len, pay_data);
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        exp_start(4'd4, 12'd2);
        exp_payload("hi");
        send_str("+IPD,4,2:hi");
        wait_drain("post_reset");
    endtask

    task automatic test_ok_detect();
`ifdef ESP_OK_DETECT_EN
        exp_ok();
`endif
        send_str("OOK\r\n");
        exp_start(4'd0, 12'd4);
        exp_payload("OK\r\n");
        send_str("+IPD,0,4:OK\r\n");
        wait_drain("ok_detect");
    endtask

    task automatic test_back_to_back();
        exp_start(4'd7, 12'd1);
        exp_payload("a");
        exp_start(4'd9, 12'd2);
        exp_payload("bc");
        send_str("+IPD,7,1:a+IPD,9,2:bc");
        wait_drain("back_to_back");
        checks++;
        if (link_id !== 4'd9 || pay_len !== 12'd2) begin
            failures++;
            $display("FAIL hold_after_done: got id=%0d len=%0d, expected id=9 len=2", link_id, pay_len);
        end
    endtask

    task automatic test_max_len();
        logic [7:0] b;
        exp_start(4'd6, 12'd2048);
        for (int i = 0; i < 2048; i++) begin
            b = 8'((i * 7 + 3) & 255);
            exp_data(b, (i == 2047));
        end
        send_str("+IPD,6,2048:");
        for (int i = 0; i < 2048; i++) send_byte(8'((i * 7 + 3) & 255));
        wait_drain("max_len");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_echo_and_embedded();
        test_bad_headers();
        test_timeout();
        test_reset_mid_frame();
        test_ok_detect();
        test_back_to_back();
        test_max_len();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/esp8266_ipd_parser.md
# esp8266_ipd_parser

Receive-side protocol parser for the ESP8266 Wi-Fi link. It sits behind the ESP8266 `uart_rx` instance and consumes its byte stream (`rx_int`/`dataout`). It hunts for multi-connection data frames of the form `+IPD,<id>,<len>:<payload>` and delivers the payload as a byte stream with link ID, length and frame delimiters. It complements the AT-command transmit sequencer, which opens the server with `CIPMUX=1`.

## Interface
- `MAX_LEN`, 2048: largest accepted payload length in bytes; larger lengths are rejected.
- `TIMEOUT`, 24'd5_000_000: idle cycles allowed between bytes inside a frame before the frame is aborted.
- `clk` in 1: system clock (same clock as `uart_rx`).
- `rst_n` in 1: asynchronous, active-low reset.
- `rx_int` in 1: from `uart_rx`; high while a byte is being received. The falling edge marks `rx_data` valid.
- `rx_data` in 8: received byte from `uart_rx.dataout`.
- `link_id` out 4: connection ID of the current frame, 0–9.
- `pay_len` out 12: declared payload length of the current frame.
- `pay_data` out 8: payload byte.
- `pay_valid` out 1: one-cycle strobe; `pay_data` is valid.
- `frame_start` out 1: one-cycle strobe on the `:` byte; `link_id` and `pay_len` are valid from this cycle until the next `frame_start`.
- `frame_done` out 1: one-cycle strobe, coincident with the last `pay_valid`.
- `frame_err` out 1: one-cycle strobe on a malformed header or a timeout.
- `ok_seen` out 1: one-cycle strobe on `OK\r\n` (only when `ESP_OK_DETECT_EN` is defined).

## Operation
- **Byte strobe `bs`**: register `rx_int` into `rx_int_d`. Then `bs = rx_int_d & ~rx_int`, and `rx_data` is captured in the same cycle. All parsing advances only on `bs`.
- **States**:
  - `HUNT`: wait for `+`.
  - `TAG`: match `I`,`P`,`D`,`,` using a 2-bit index.
  - `ID`: read one digit, then expect `,`.
  - `LEN`: read 1–4 digits, then expect `:`.
  - `PAY`: byte count down.
- **`HUNT`**: a `+` moves to `TAG` with index 0. Any other byte is ignored.
- **`TAG`**: a match advances the index; after the `,` go to `ID`. On a mismatch, go to `HUNT`. Exception: if the mismatching byte is `+`, stay in `TAG` with index reset to 0. A tag mismatch is not an error (normal AT echo traffic).
- **`ID`**:
  - The first byte must be `0`–`9`; load `id_r`.
  - The next byte must be `,`; clear the 14-bit length accumulator `acc`, clear the digit count, go to `LEN`.
  - Any other byte: `frame_err`, go to `HUNT`.
- **`LEN`**:
  - A digit updates `acc <= acc*10 + (byte-8'h30)` and increments the digit count.
  - A fifth digit: `frame_err`, go to `HUNT`.
  - `:` with count 0, `acc==0`, or `acc>MAX_LEN`: `frame_err`, go to `HUNT`.
  - Otherwise `:` does the following: `link_id<=id_r`, `pay_len<=acc[11:0]`, `remain<=acc`, `frame_start`, go to `PAY`.
  - Any other byte: `frame_err`, go to `HUNT`.
- **`PAY`**:
  - Every `bs` outputs the byte with `pay_valid` and decrements `remain`. Bytes are transparent: `+` inside the payload is data.
  - When `remain==1` at `bs`, also assert `frame_done` and go to `HUNT`.
- **Timeout**:
  - A counter clears on every `bs` and whenever the state is `HUNT`, and increments otherwise.
  - Reaching `TIMEOUT-1` in any non-`HUNT` state gives `frame_err` and a return to `HUNT`.
  - A timeout and a `bs` in the same cycle: the byte wins and the counter clears.
- **Reset**: all outputs go to 0, state goes to `HUNT`, and all counters clear. Reset mid-frame discards the frame with no `frame_done` and no `frame_err`.

## Timing
- Let `bs` be high at edge N. Then `pay_valid`, `pay_data`, `frame_start`, `frame_done`, `frame_err` and `ok_seen` are registered high for exactly cycle N+1, and low at N+2 unless another `bs` occurs.
- Consecutive `bs` events are at least one UART byte time apart. The block imposes no back-pressure, and a strobe that is missed is lost.
- `frame_start` and the first `pay_valid` are never in the same cycle. A frame needs at least one payload byte.
- `link_id` and `pay_len` hold their values after `frame_done` until the next `frame_start`. Their reset value is 0.

## Configuration
- `ESP_OK_DETECT_EN` defined:
  - An independent 2-bit matcher runs in parallel in all states except `PAY`.
  - It matches `O`,`K`,`\r`,`\n`, restarting on `O`.
  - A full match pulses `ok_seen` with the same one-cycle latency as the other strobes.
- Not defined: the matcher logic is absent and `ok_seen` is tied to 0.

## Test plan
- Stream `+IPD,0,3:abc` → `frame_start` with `link_id=0` and `pay_len=3`. Then `pay_valid` three times with 0x61, 0x62, 0x63. `frame_done` is coincident with 0x63. No `frame_err`.
- Stream `AT+CIPMUX=1\r\n+IPD,3,12:+IPD,0,1:xx` → exactly one frame: `link_id=3`, `pay_len=12`. The embedded `+IPD` bytes are delivered as payload. No second `frame_start`.
- Stream each header in turn: `+IPD,0,0:`, `+IPD,0,2049:`, `+IPD,0,12345:`, `+IPD,A,1:` → one `frame_err` each, no `frame_start`. A following `+IPD,1,1:z` parses normally.
- Send `+IPD,2,5:ab` and then go idle for `TIMEOUT` cycles → `frame_err` one cycle after the limit. The next `+IPD,2,1:q` succeeds.
- Assert `rst_n` low while in `PAY` → all outputs read 0 during reset. After release, `+IPD,4,2:hi` yields `link_id=4` and two bytes.
- With `ESP_OK_DETECT_EN` defined, stream `OOK\r\n` then `+IPD,0,4:OK\r\n` → one `ok_seen`, for the first sequence only. Without the macro, `ok_seen` stays 0.
